bus_uart_tx: RTL
================

# bus_uart_tx

Bus-side serial output port for the Procco CPU, and the transmit counterpart of the `Cin` user-input port. When the instruction decoder asserts `tx_read`, the block latches one 32-bit word from the shared bus. It then shifts that word out on a UART line as four 8N1 bytes, least-significant byte first, and reports `tx_busy` and `tx_done` so the control logic can stall the way it does on `cin_done`.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: system clock frequency.
- `BAUD`, default 115_200: line rate.
- `BUS_W`, default 32: bus width. The block supports only 32 (4 bytes).
- `CLKS_PER_BIT`, derived: `CLK_FREQ_HZ/BAUD`, rounded to nearest. Must be ≥ 2, checked by elaboration assertion.

- `clk` — in, 1: single system clock. All logic on its rising edge.
- `reset_n` — in, 1: synchronous, active-low reset.
- `bus` — in, `BUS_W`: shared tri0 bus. This block only samples it and never drives it.
- `tx_read` — in, 1: control strobe. Capture `bus` and start a frame.
- `tx_busy` — out, 1: high while a frame is in progress.
- `tx_done` — out, 1: one-cycle pulse when the last stop bit completes.
- `tx` — out, 1: serial line, idle high. Driven from a flop.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, all counters 0.
- States and transitions:
  - IDLE → START when `tx_read`=1. The same edge loads the shift register with `bus` and sets byte index to 0.
  - START (tx=0, one bit time) → DATA.
  - DATA: 8 bits, LSB first, one bit time each. After bit 7 → STOP.
  - STOP (tx=1, one bit time):
    - if byte index < 3: increment byte index, shift register right by 8, → START;
    - if byte index = 3: → IDLE and pulse `tx_done`.
- Byte order on the line for word 0xAABBCCDD: DD, CC, BB, AA. No gap between bytes beyond the stop bit.
- `tx_busy` = (state ≠ IDLE). It is registered, with no combinational path from `tx_read`.
- `tx_read` while busy is ignored; the frame in progress is unaffected. The decoder must wait for `tx_done`, or for `tx_busy`=0, before reasserting.
- The bus is sampled only on the accepting edge. Later bus activity has no effect.
- Reset asserted mid-frame: the next edge returns everything to reset values. `tx` goes to 1 and no `tx_done` is produced. The aborted byte is not resumed.

## Timing
- `tx_read` high at edge k (state IDLE):
  - `tx` falls and `tx_busy` rises after edge k;
  - the start bit occupies cycles k+1 … k+CLKS_PER_BIT.
- Each bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter. The counter reloads to 0 at every bit boundary and is held at 0 in IDLE.
- A frame occupies 40·CLKS_PER_BIT cycles.
- `tx_done` is high for the single cycle after the final stop bit's last cycle. `tx_busy` falls on that same edge.
- `tx_read` during the `tx_done` cycle is accepted (state is IDLE), giving back-to-back frames with zero idle bits.
- Latency from `tx_read` to first data bit: CLKS_PER_BIT+1 cycles.

## Structure
- `procco_pkg` holds:
  - `typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t`;
  - `localparam BUS_W = 32`;
  - the UART 8N1 constants: `UART_DATA_BITS=8`, `UART_BYTES_PER_WORD=4`.
- Sub-module `uart_baud_tick`:
  - parameter `CLKS_PER_BIT`;
  - inputs `clk`, `reset_n`, `clear`;
  - output one-cycle `tick` at the end of each bit time.
  - It is reused by a later UART receiver.
- Top of `bus_uart_tx`: FSM, 32-bit shift register, 3-bit bit index, 2-bit byte index.
- Instantiated in `Procco` alongside `Output_SEG`. The decoder gains `tx_read` and consumes `tx_done`.

## Test plan
- Parameters CLK_FREQ_HZ=4, BAUD=1 (CLKS_PER_BIT=4). `bus`=0xAABBCCDD, `tx_read` pulse for 1 cycle → line decodes to DD, CC, BB, AA with correct start/stop bits. `tx_busy` is high for 160 cycles, then `tx_done` pulses once.
- `bus`=0x00000000, then 0xFFFFFFFF → bit timing exact at 4 cycles/bit, and the stop bit is high between identical bytes.
- `tx_read` reasserted at cycle 50 mid-frame with `bus`=0x12345678 → ignored; the line still carries the original word and exactly one `tx_done` is produced.
- `tx_read` asserted in the `tx_done` cycle with `bus`=0x01020304 → second frame starts the next cycle: start bit immediately after stop, bytes 04, 03, 02, 01.
- `reset_n` low for 1 cycle at cycle 70 → `tx`=1, `tx_busy`=0 after that edge. No `tx_done`. A subsequent `tx_read` transmits normally.
- `bus` changed every cycle after acceptance → transmitted word equals the value sampled at the accepting edge.

Source files
------------

// File: rtl/procco_pkg.sv
// rtl/procco_pkg.sv - shared types and constants for the Procco bus UART transmitter
package procco_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam int BUS_W               = 32;
  localparam int UART_DATA_BITS      = 8;
  localparam int UART_BYTES_PER_WORD = 4;

endpackage

// File: rtl/bus_uart_tx_if.sv
// rtl/bus_uart_tx_if.sv - decoder/bus side handshake of the serial output port
interface bus_uart_tx_if;
  import procco_pkg::*;

  logic [BUS_W-1:0] bus;
  logic             tx_read;
  logic             tx_busy;
  logic             tx_done;
  logic             tx;

  modport master (output bus, tx_read, input tx_busy, tx_done, tx);
  modport slave  (input bus, tx_read, output tx_busy, tx_done, tx);

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-time counter emitting a one-cycle tick at the end of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clear && (cnt_q == LAST);

  // The count restarts at every bit boundary so consecutive bits never drift.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// rtl/bus_uart_tx.sv - latches one bus word on tx_read and sends it as four 8N1 bytes, LSB byte first
module bus_uart_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int BUS_W       = 32
) (
  input logic          clk,
  input logic          reset_n,
  bus_uart_tx_if.slave bif
);
  import procco_pkg::*;

  localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("bus_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (BUS_W != procco_pkg::BUS_W) begin : g_bus_w_check
    $error("bus_uart_tx: only a 32-bit bus is supported");
  end

  tx_state_t        state_q, state_d;
  logic [BUS_W-1:0] shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       cur_byte;
  logic             tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_q == TX_IDLE),
    .tick   (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    done_d     = 1'b0;
    cur_byte   = '0;
    tx_d       = 1'b1;

    unique case (state_q)
      TX_IDLE: begin
        if (bif.tx_read) begin
          state_d    = TX_START;
          shift_d    = bif.bus;
          bit_idx_d  = '0;
          byte_idx_d = '0;
        end
      end
      TX_START: begin
        if (tick) begin
          state_d   = TX_DATA;
          bit_idx_d = '0;
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (byte_idx_q == 2'(UART_BYTES_PER_WORD - 1)) begin
            state_d = TX_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = TX_START;
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = shift_q >> UART_DATA_BITS;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // The line level is decoded from the next state so tx stays a plain flop.
    cur_byte = shift_d[7:0];
    unique case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = cur_byte[bit_idx_d];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != TX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= TX_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bif.tx      = tx_q;
  assign bif.tx_busy = busy_q;
  assign bif.tx_done = done_q;

endmodule
